eth_rx_idma_sequencer: RTL
==========================

// Module: eth_rx_idma_sequencer
// PURPOSE
//  Ingress-side counterpart of the TX request path: snoops the RX AXI-Stream (CDC FIFO output -> iDMA AXIS read port),
//  measures each frame and issues one AXIS->AXI iDMA request per frame into a ring of fixed-size buffer slots.
//  Sits in the system clock domain beside the iDMA backend; software frees slots; completion raises an IRQ pulse.
// PARAMETERS
//  DataWidth    32  AXIS data width (bits); tkeep width = DataWidth/8
//  AddrWidth    32  iDMA destination address width
//  TFLenWidth   32  iDMA length width; frame byte counter width
//  SlotLog2     11  log2 slot size in bytes (2048 B slots)
//  NumSlots      8  ring slots, power of two, >=2
//  LenFifoDepth  4  queued frame descriptors, >=2
// PORTS
//  clk_i            in   1                system clock
//  rst_i            in   1                synchronous active-high reset
//  cfg_enable_i     in   1                allow request issue
//  cfg_base_addr_i  in   AddrWidth        ring base address; slot-aligned
//  cfg_drop_addr_i  in   AddrWidth        scratch sink for oversize frames
//  rx_tvalid_i      in   1                snooped AXIS tvalid
//  rx_tready_i      in   1                snooped AXIS tready (post-gate)
//  rx_tlast_i       in   1                snooped AXIS tlast
//  rx_tkeep_i       in   DataWidth/8      snooped AXIS tkeep
//  rx_gate_o        out  1                AND into tready: 0 = descriptor FIFO full
//  req_valid_o      out  1                iDMA request valid
//  req_ready_i      in   1                iDMA request ready
//  req_length_o     out  TFLenWidth       transfer bytes
//  req_dst_addr_o   out  AddrWidth        destination address
//  rsp_valid_i      in   1                iDMA response valid
//  rsp_ready_o      out  1                iDMA response ready
//  rsp_error_i      in   1                response carries error
//  sw_release_i     in   1                one-cycle pulse: software frees oldest slot
//  slots_used_o     out  $clog2(NumSlots)+1  filled, unreleased slots
//  wr_slot_o        out  $clog2(NumSlots) next slot index
//  frame_cnt_o      out  32               frames written to ring
//  drop_cnt_o       out  16               oversize + zero-length frames
//  err_cnt_o        out  16               error responses
//  irq_o            out  1                one-cycle pulse per ring completion
// BEHAVIOUR
//  Reset: all outputs 0 except rx_gate_o=1; counters, pointers, FIFO and FSM cleared. Reset mid-transfer aborts
//   tracking; backend and CDC FIFO are reset together with this block.
//  Beat = rx_tvalid_i & rx_tready_i. Per beat acc += popcount(rx_tkeep_i), saturating at 2^TFLenWidth-1.
//   On tlast beat: push {len=acc+popcount, oversize=len>2^SlotLog2, zero=len==0}; acc <= 0 the same cycle.
//  rx_gate_o = !fifo_full (registered-state driven, no comb path from rx_* inputs). A push and pop in the
//   same cycle on a full FIFO is legal; gate still reads full that cycle.
//  Zero-length entries are popped in IDLE without a request; drop_cnt_o++.
//  FSM IDLE/ISSUE/WAIT_RSP:
//   IDLE: fifo non-empty & cfg_enable_i & (oversize | slots_used_o<NumSlots) -> latch head, pop, ISSUE.
//    Normal: dst = cfg_base_addr_i + (wr_slot << SlotLog2). Oversize: dst = cfg_drop_addr_i; full length (drains stream).
//   ISSUE: req_valid_o=1, fields stable until req_ready_i; then WAIT_RSP. Valid never drops without ready.
//   WAIT_RSP: rsp_ready_o=1; on rsp_valid_i -> IDLE. Normal frame: wr_slot++ (wraps NumSlots-1 -> 0),
//    slots_used++, frame_cnt++, irq_o=1 next cycle; error additionally err_cnt++ (slot still consumed).
//    Oversize: drop_cnt++, no slot/irq; error still err_cnt++.
//  Latency: tlast beat in cycle N with FSM idle -> req_valid_o in N+2.
//  sw_release_i: slots_used-- if >0, else ignored. Simultaneous completion + release: net unchanged.
//  Ring full: FSM waits in IDLE; descriptors and AXIS back-pressure via gate; no frame lost.
//  cfg_enable_i deassert only blocks new issue; ISSUE/WAIT_RSP complete. Counters wrap; drop/err saturate.
// TESTING
//  Reset: 3-beat frame, tkeep 4'hF,4'hF,4'h3 (32b) -> req len 10, dst base+0; rsp -> irq 1 cycle, frame_cnt 1.
//  Ring wrap: NumSlots=8, 9 frames, release after 8th -> 9th dst = base+0, wr_slot 1, slots_used 8.
//  Full ring: 8 frames unreleased, 4 more -> no req_valid, rx_gate_o 0 once 4 queued; release -> next issues.
//  Oversize: 2100-byte frame -> dst=cfg_drop_addr_i, len 2100, drop_cnt 1, no irq, slot unchanged.
//  Zero-length: tlast with tkeep 0 -> no request, drop_cnt 1; error rsp -> err_cnt 1, slot consumed.
//  Same-cycle completion + sw_release_i at slots_used 3 -> stays 3; reset during WAIT_RSP -> all cleared.

Source files
------------

// File: rtl/eth_rx_idma_sequencer.sv
// RX frame sequencer: measures each snooped AXIS frame and issues one AXIS->AXI iDMA
// request per frame into a ring of fixed-size buffer slots, with software slot release.
module eth_rx_idma_sequencer #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned TFLenWidth   = 32,
    parameter int unsigned SlotLog2     = 11,
    parameter int unsigned NumSlots     = 8,
    parameter int unsigned LenFifoDepth = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cfg_enable_i,
    input  logic [AddrWidth-1:0]        cfg_base_addr_i,
    input  logic [AddrWidth-1:0]        cfg_drop_addr_i,
    input  logic                        rx_tvalid_i,
    input  logic                        rx_tready_i,
    input  logic                        rx_tlast_i,
    input  logic [DataWidth/8-1:0]      rx_tkeep_i,
    output logic                        rx_gate_o,
    output logic                        req_valid_o,
    input  logic                        req_ready_i,
    output logic [TFLenWidth-1:0]       req_length_o,
    output logic [AddrWidth-1:0]        req_dst_addr_o,
    input  logic                        rsp_valid_i,
    output logic                        rsp_ready_o,
    input  logic                        rsp_error_i,
    input  logic                        sw_release_i,
    output logic [$clog2(NumSlots):0]   slots_used_o,
    output logic [$clog2(NumSlots)-1:0] wr_slot_o,
    output logic [31:0]                 frame_cnt_o,
    output logic [15:0]                 drop_cnt_o,
    output logic [15:0]                 err_cnt_o,
    output logic                        irq_o
);

    localparam int unsigned KeepWidth    = DataWidth / 8;
    localparam int unsigned PopWidth     = $clog2(KeepWidth) + 1;
    localparam int unsigned SlotIdxWidth = $clog2(NumSlots);
    localparam int unsigned UsedWidth    = SlotIdxWidth + 1;
    localparam int unsigned PtrWidth     = $clog2(LenFifoDepth);
    localparam int unsigned CntWidth     = $clog2(LenFifoDepth + 1);
    localparam logic [TFLenWidth:0] SlotBytes = {{TFLenWidth{1'b0}}, 1'b1} << SlotLog2;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StWaitRsp = 2'd2;

    function automatic logic [PopWidth-1:0] popcount(input logic [KeepWidth-1:0] v);
        logic [PopWidth-1:0] n;
        n = '0;
        for (int i = 0; i < KeepWidth; i++) begin
            n = n + PopWidth'(v[i]);
        end
        return n;
    endfunction

    logic [TFLenWidth-1:0] acc;
    logic [TFLenWidth:0]   sum_wide;
    logic [TFLenWidth-1:0] len_next;
    logic                  beat;

    logic [TFLenWidth-1:0] fifo_len  [LenFifoDepth];
    logic                  fifo_ovs  [LenFifoDepth];
    logic                  fifo_zero [LenFifoDepth];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CntWidth-1:0]   fifo_cnt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    logic [1:0] state;
    logic       cur_ovs;
    logic       issue;
    logic       drop_zero;
    logic       complete;
    logic       slot_done;
    logic       rel_ok;

    assign beat     = rx_tvalid_i & rx_tready_i;
    assign sum_wide = {1'b0, acc} + (TFLenWidth + 1)'(popcount(rx_tkeep_i));
    assign len_next = sum_wide[TFLenWidth] ? '1 : sum_wide[TFLenWidth-1:0];

    assign fifo_full  = (fifo_cnt == CntWidth'(LenFifoDepth));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = beat & rx_tlast_i & (~fifo_full | pop);

    // The gate depends only on FIFO occupancy so no combinational path exists from rx_* inputs.
    assign rx_gate_o   = ~fifo_full;
    assign req_valid_o = (state == StIssue);
    assign rsp_ready_o = (state == StWaitRsp);

    assign complete  = (state == StWaitRsp) & rsp_valid_i;
    assign slot_done = complete & ~cur_ovs;
    assign rel_ok    = sw_release_i & (slots_used_o != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc <= '0;
        end else if (beat) begin
            acc <= rx_tlast_i ? '0 : len_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_len[wr_ptr]  <= len_next;
            fifo_ovs[wr_ptr]  <= ({1'b0, len_next} > SlotBytes);
            fifo_zero[wr_ptr] <= (len_next == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PtrWidth'(LenFifoDepth - 1)) ? '0 : wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrWidth'(LenFifoDepth - 1)) ? '0 : rd_ptr + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CntWidth'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CntWidth'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Zero-length descriptors are discarded without an enable check; oversize ones bypass the ring-full stall.
    always_comb begin
        pop       = 1'b0;
        issue     = 1'b0;
        drop_zero = 1'b0;
        if ((state == StIdle) && !fifo_empty) begin
            if (fifo_zero[rd_ptr]) begin
                pop       = 1'b1;
                drop_zero = 1'b1;
            end else if (cfg_enable_i &&
                         (fifo_ovs[rd_ptr] || (slots_used_o < UsedWidth'(NumSlots)))) begin
                pop   = 1'b1;
                issue = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= StIdle;
            cur_ovs        <= 1'b0;
            req_length_o   <= '0;
            req_dst_addr_o <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (issue) begin
                        state          <= StIssue;
                        cur_ovs        <= fifo_ovs[rd_ptr];
                        req_length_o   <= fifo_len[rd_ptr];
                        req_dst_addr_o <= fifo_ovs[rd_ptr] ? cfg_drop_addr_i :
                                          cfg_base_addr_i + (AddrWidth'(wr_slot_o) << SlotLog2);
                    end
                end
                StIssue: begin
                    if (req_ready_i) begin
                        state <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (rsp_valid_i) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_slot_o    <= '0;
            slots_used_o <= '0;
            frame_cnt_o  <= '0;
            drop_cnt_o   <= '0;
            err_cnt_o    <= '0;
            irq_o        <= 1'b0;
        end else begin
            irq_o <= slot_done;
            if (slot_done) begin
                wr_slot_o   <= wr_slot_o + SlotIdxWidth'(1);
                frame_cnt_o <= frame_cnt_o + 32'd1;
            end
            if (slot_done && !rel_ok) begin
                slots_used_o <= slots_used_o + UsedWidth'(1);
            end else if (!slot_done && rel_ok) begin
                slots_used_o <= slots_used_o - UsedWidth'(1);
            end
            if ((drop_zero || (complete && cur_ovs)) && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            if (complete && rsp_error_i && (err_cnt_o != 16'hFFFF)) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end

endmodule
